// File: rtl/int_ctrl.sv
// Interrupt/reset sequencer for the 6502 core: synchronises NMI and IRQ lines,
// samples them at instruction boundaries and holds the chosen vector until mcode acks.
module int_ctrl #(
   parameter int IRQ_CHANNELS = 4,
   parameter int SRC_BITS     = 2,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    sync,
   input  logic                    nmi_n,
   input  logic [IRQ_CHANNELS-1:0] irq_n,
   input  logic [IRQ_CHANNELS-1:0] irq_en,
   input  logic                    i_flag,
   input  logic                    ack,
   output logic                    rst,
   output logic                    nmi,
   output logic                    irq,
   output logic [SRC_BITS-1:0]     irq_src,
   output logic [7:0]              vec_l,
   output logic [IRQ_CHANNELS-1:0] irq_pending
);

   typedef enum logic [1:0] {ST_IDLE, ST_RESET, ST_NMI, ST_IRQ} state_t;

   function automatic logic [7:0] vec_of(input state_t s);
      case (s)
         ST_RESET: vec_of = 8'hFC;
         ST_NMI:   vec_of = 8'hFA;
         default:  vec_of = 8'hFE;
      endcase
   endfunction

   state_t                                   state_q, state_d;
   logic [SYNC_STAGES-1:0]                   nmi_sync_q, nmi_sync_d;
   logic [SYNC_STAGES-1:0][IRQ_CHANNELS-1:0] irq_sync_q, irq_sync_d;
   logic                                     nmi_hist_q, nmi_hist_d;
   logic                                     nmi_latch_q, nmi_latch_d;
   logic [SRC_BITS-1:0]                      src_q, src_d;
   logic                                     rst_q, rst_d;
   logic                                     nmi_q, nmi_d;
   logic                                     irq_q, irq_d;
   logic [7:0]                               vec_q, vec_d;

   logic                    nmi_s;
   logic                    nmi_fall;
   logic                    irq_any;
   logic                    latch_clr;
   logic [SRC_BITS-1:0]     win_idx;

   // Stage 0 sits at the LSB end; the MSB stage is the synchronised value.
   assign nmi_sync_d  = {nmi_sync_q[SYNC_STAGES-2:0], nmi_n};
   assign irq_sync_d  = {irq_sync_q[SYNC_STAGES-2:0], irq_n};
   assign nmi_s       = nmi_sync_q[SYNC_STAGES-1];
   assign nmi_hist_d  = nmi_s;
   assign nmi_fall    = nmi_hist_q & ~nmi_s;
   assign irq_pending = ~irq_sync_q[SYNC_STAGES-1] & irq_en;
   assign irq_any     = (|irq_pending) & ~i_flag;

   // Scan downwards so the lowest asserted index is the last one written.
   always_comb begin
      win_idx = '0;
      for (int i = IRQ_CHANNELS - 1; i >= 0; i--) begin
         if (irq_pending[i]) win_idx = SRC_BITS'(i);
      end
   end

   always_comb begin
      state_d   = state_q;
      src_d     = src_q;
      latch_clr = 1'b0;
      case (state_q)
         ST_RESET: if (ack) state_d = ST_IDLE;
         ST_NMI: begin
            if (ack) begin
               state_d   = ST_IDLE;
               latch_clr = 1'b1;
            end
         end
         ST_IRQ:   if (ack) state_d = ST_IDLE;
         ST_IDLE: begin
            if (sync) begin
               if (nmi_latch_q) begin
                  state_d = ST_NMI;
               end else if (irq_any) begin
                  state_d = ST_IRQ;
                  src_d   = win_idx;
               end
            end
         end
         default: state_d = ST_RESET;
      endcase
      // A fresh edge outranks the clear from an ack in the same cycle.
      nmi_latch_d = nmi_fall ? 1'b1 : (latch_clr ? 1'b0 : nmi_latch_q);
      rst_d       = (state_d == ST_RESET);
      nmi_d       = (state_d == ST_NMI);
      irq_d       = (state_d == ST_IRQ);
      vec_d       = vec_of(state_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RESET;
         nmi_sync_q  <= '1;
         irq_sync_q  <= '1;
         nmi_hist_q  <= 1'b1;
         nmi_latch_q <= 1'b0;
         src_q       <= '0;
         rst_q       <= 1'b1;
         nmi_q       <= 1'b0;
         irq_q       <= 1'b0;
         vec_q       <= 8'hFC;
      end else begin
         state_q     <= state_d;
         nmi_sync_q  <= nmi_sync_d;
         irq_sync_q  <= irq_sync_d;
         nmi_hist_q  <= nmi_hist_d;
         nmi_latch_q <= nmi_latch_d;
         src_q       <= src_d;
         rst_q       <= rst_d;
         nmi_q       <= nmi_d;
         irq_q       <= irq_d;
         vec_q       <= vec_d;
      end
   end

   assign rst     = rst_q;
   assign nmi     = nmi_q;
   assign irq     = irq_q;
   assign irq_src = src_q;
   assign vec_l   = vec_q;

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Parametrised interrupt/reset sequencer for the 6502 core. It replaces the fixed int_seq, whose NMI and IRQ inputs are tied inactive.
- Synchronises an NMI line and N level-sensitive IRQ channels.
- Edge-detects NMI, masks and prioritises the IRQ channels, and samples all requests only at instruction boundaries (sync).
- Presents a registered rst/nmi/irq decision plus vector low byte to mcode, and holds it until mcode acknowledges the vector fetch.

Parameters:
- IRQ_CHANNELS, 4: number of active-low IRQ request lines.
- SRC_BITS, 2: width of irq_src; must satisfy 2**SRC_BITS >= IRQ_CHANNELS.
- SYNC_STAGES, 2: flip-flop stages per input synchroniser; minimum 2.

Ports:
- clk  in  1  core clock; all flops on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sync  in  1  instruction-boundary strobe (next_sync from inst_seq).
- nmi_n  in  1  asynchronous NMI request, falling-edge triggered.
- irq_n  in  IRQ_CHANNELS  asynchronous IRQ requests, active-low level, one bit per channel.
- irq_en  in  IRQ_CHANNELS  per-channel enable; 1 = enabled; synchronous to clk.
- i_flag  in  1  SR interrupt-disable bit.
- ack  in  1  one-cycle pulse from mcode when the vector high byte has been fetched.
- rst  out  1  reset sequence in service.
- nmi  out  1  NMI sequence in service.
- irq  out  1  IRQ sequence in service.
- irq_src  out  SRC_BITS  index of the serviced IRQ channel.
- vec_l  out  8  vector low byte: FC in RESET, FA in NMI, FE otherwise.
- irq_pending  out  IRQ_CHANNELS  synchronised, irq_en-masked request status; not gated by i_flag.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=RESET; rst=1, nmi=0, irq=0, irq_src=0, vec_l=8'hFC, irq_pending=0.
  - All synchroniser flops and the NMI history flop reset to 1 (inactive); nmi_latch=0.
- Synchronisers:
  - Each nmi_n/irq_n bit passes through SYNC_STAGES flops.
  - irq_pending[i] = ~irq_n_sync[i] & irq_en[i]; this is combinational from the synchronised value.
- NMI edge detect:
  - nmi_latch sets on a synchronised 1->0 transition.
  - A low level held indefinitely sets it only once; nmi_n must be sampled high (after sync) for at least 1 clock to re-arm.
  - Latency: nmi_n first sampled low at edge 0 -> nmi_latch=1 after edge SYNC_STAGES.
- IRQ priority: lowest-index asserted bit of irq_pending wins. irq_any = |irq_pending & ~i_flag.
- Requests are level-sensitive and not latched. A request withdrawn before sync is lost.
- FSM states: IDLE, RESET, NMI, IRQ. Outputs are registered, one-hot from state.
  - RESET -> IDLE on ack.
  - IDLE with sync=1, evaluated at the rising edge in this order:
    - nmi_latch -> NMI.
    - else irq_any -> IRQ, with irq_src = winning index.
    - else stay IDLE.
  - IDLE with sync=0: stay; nothing is evaluated.
  - NMI -> IDLE on ack; nmi_latch clears in the same edge.
  - IRQ -> IDLE on ack; irq_src holds its value until the next IRQ entry.
  - In RESET/NMI/IRQ, sync is ignored. Inputs keep being synchronised and nmi_latch can still set.
- Simultaneous events:
  - NMI edge detected in the same cycle as ack in NMI: set wins. nmi_latch stays 1 and is serviced at the next IDLE sync.
  - NMI edge detected in the same cycle as sync in IDLE: evaluation uses the pre-edge nmi_latch (0). The NMI is taken at the following sync.
  - ack in IDLE: ignored. ack and sync together in NMI/IRQ: ack wins; no evaluation that cycle.
  - i_flag changing in the same cycle as sync: the value present at the edge is used.
- Reset mid-service: rst_n low forces RESET immediately and clears any pending NMI.
- vec_l is a pure function of the registered state; no extra latency.

Test Plan (IRQ_CHANNELS=4, SYNC_STAGES=2):
1. Reset + first fetch:
   - Assert rst_n=0, release, pulse sync -> rst=1, vec_l=FC persists through sync.
   - ack -> next cycle rst=0, vec_l=FE, state IDLE.
2. NMI latency and edge rule:
   - Drop nmi_n at edge 0, hold low -> nmi_latch after edge 2. sync at edge 3 -> nmi=1, vec_l=FA. ack -> nmi=0.
   - Further syncs with nmi_n still low -> no NMI.
   - Raise nmi_n for 3 clocks, lower again -> NMI taken again.
3. IRQ priority/masking:
   - irq_n=4'b0101 (ch1, ch3 low), irq_en=4'b1111, i_flag=0, sync -> irq=1, irq_src=1, irq_pending=4'b1010.
   - Same with irq_en=4'b1101 -> irq_src=3.
   - i_flag=1 -> no irq; irq_pending still 4'b1000.
4. NMI over IRQ:
   - NMI latched and irq_n[0] low at the same sync -> nmi=1, irq=0.
   - After ack, next sync -> irq=1, irq_src=0.
5. Collisions:
   - New NMI edge coincident with ack in NMI -> nmi drops for one cycle, reasserts at next sync.
   - ack+sync together in IRQ -> IDLE; no re-entry until the following sync.
6. Mid-service reset:
   - In IRQ state, pulse rst_n low for 1 ns between edges -> rst=1, irq=0, vec_l=FC immediately (asynchronous), pending NMI cleared.
